// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a single-ported word data memory.
// Define MISALIGN_TRAP_EN to report misaligned half/word accesses as illegal ops.
module mem_access_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err
);

  typedef enum logic [1:0] {StIdle, StAccess, StFinish} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [ADDR_W-1:0]   r_dm_addr;
  logic                r_dm_we;
  logic [3:0]          r_dm_be;
  logic [31:0]         r_dm_wdata;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic [4:0]          r_rd;
  logic                r_load;
  logic [7:0]          r_cnt;
  logic                r_fin_wb;
  logic                r_fin_err;
  logic [4:0]          r_wb_rd;
  logic [31:0]         r_wb_data;

  logic                w_accept;
  logic                w_is_mem;
  logic                w_misalign;
  logic                w_illegal;
  logic                w_start;
  logic                w_timeout;
  logic                w_fin_wb;
  logic                w_fin_err;
  logic [1:0]          w_off;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [7:0]          w_lane_b;
  logic [15:0]         w_lane_h;
  logic [31:0]         w_ld_data;
  logic                w_unused;

  assign w_unused = ^ex_addr[31:ADDR_W+2];

  assign w_accept  = ex_valid && (r_state == StIdle);
  assign w_is_mem  = ex_load || ex_store;
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  assign w_misalign = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));

  always_comb begin
    w_illegal = 1'b0;
    if (ex_load && ex_store) begin
      w_illegal = 1'b1;
    end else if (ex_load) begin
      w_illegal = !(ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (ex_store) begin
      w_illegal = !(ex_funct3 inside {3'b000, 3'b001, 3'b010});
    end
`ifdef MISALIGN_TRAP_EN
    if (w_is_mem && w_misalign) begin
      w_illegal = 1'b1;
    end
`endif
  end

  assign w_start = w_accept && w_is_mem && !w_illegal;

  // Misaligned halves/words have their offending low bits dropped.
  always_comb begin
    w_off = ex_addr[1:0];
    if (ex_funct3[1:0] == 2'b10) begin
      w_off = 2'b00;
    end else if (ex_funct3[1:0] == 2'b01) begin
      w_off = {ex_addr[1], 1'b0};
    end
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_wdata;
    if (ex_store) begin
      case (ex_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_off;
          w_wdata = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << w_off;
          w_wdata = {2{ex_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = ex_wdata;
        end
      endcase
    end
  end

  always_comb begin
    w_lane_b = dm_rdata[7:0];
    case (r_off)
      2'd0:    w_lane_b = dm_rdata[7:0];
      2'd1:    w_lane_b = dm_rdata[15:8];
      2'd2:    w_lane_b = dm_rdata[23:16];
      default: w_lane_b = dm_rdata[31:24];
    endcase
    w_lane_h = r_off[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (r_funct3)
      3'b000:  w_ld_data = {{24{w_lane_b[7]}}, w_lane_b};
      3'b001:  w_ld_data = {{16{w_lane_h[15]}}, w_lane_h};
      3'b100:  w_ld_data = {24'd0, w_lane_b};
      3'b101:  w_ld_data = {16'd0, w_lane_h};
      default: w_ld_data = dm_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_fin_wb     = 1'b0;
    w_fin_err    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept && w_is_mem) begin
          if (w_illegal) begin
            w_state_next = StFinish;
            w_fin_err    = 1'b1;
          end else begin
            w_state_next = StAccess;
          end
        end
      end
      StAccess: begin
        if (dm_ack) begin
          w_state_next = StFinish;
          w_fin_wb     = r_load;
        end else if (w_timeout) begin
          w_state_next = StFinish;
          w_fin_err    = 1'b1;
        end
      end
      StFinish: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_dm_addr  <= '0;
      r_dm_we    <= 1'b0;
      r_dm_be    <= 4'b0000;
      r_dm_wdata <= 32'd0;
      r_funct3   <= 3'b000;
      r_off      <= 2'b00;
      r_rd       <= 5'd0;
      r_load     <= 1'b0;
      r_cnt      <= 8'd0;
      r_fin_wb   <= 1'b0;
      r_fin_err  <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next == StFinish) begin
        r_fin_wb  <= w_fin_wb;
        r_fin_err <= w_fin_err;
      end
      if (w_start) begin
        r_dm_addr  <= ex_addr[ADDR_W+1:2];
        r_dm_we    <= ex_store;
        r_dm_be    <= w_be;
        r_dm_wdata <= w_wdata;
        r_funct3   <= ex_funct3;
        r_off      <= w_off;
        r_rd       <= ex_rd;
        r_load     <= ex_load;
        r_cnt      <= 8'd0;
      end else if (r_state == StAccess) begin
        r_cnt <= r_cnt + 8'd1;
      end
      // Load result is captured at the ack edge so it is stable through FINISH and after.
      if ((r_state == StAccess) && dm_ack && r_load) begin
        r_wb_data <= w_ld_data;
        r_wb_rd   <= r_rd;
      end
    end
  end

  assign ex_ready = (r_state == StIdle);
  assign dm_req   = (r_state == StAccess);
  assign dm_we    = dm_req && r_dm_we;
  assign dm_be    = r_dm_be;
  assign dm_addr  = r_dm_addr;
  assign dm_wdata = r_dm_wdata;
  assign wb_valid = (r_state == StFinish) && r_fin_wb;
  assign wb_we    = wb_valid && (r_wb_rd != 5'd0);
  assign wb_rd    = r_wb_rd;
  assign wb_data  = r_wb_data;
  assign err      = (r_state == StFinish) && r_fin_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT = 15, ADDR_W = 10).
module tb_mem_access_unit;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_load = 1'b0;
  logic        ex_store = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_addr = 32'd0;
  logic [31:0] ex_wdata = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [9:0]  dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack = 1'b0;
  logic [31:0] dm_rdata = 32'h12F0_3456;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.ADDR_W(10), .TIMEOUT(15)) dut (
    .clk1     (clk1),
    .rst      (rst),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_load  (ex_load),
    .ex_store (ex_store),
    .ex_funct3(ex_funct3),
    .ex_addr  (ex_addr),
    .ex_wdata (ex_wdata),
    .ex_rd    (ex_rd),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_ack   (dm_ack),
    .dm_rdata (dm_rdata),
    .wb_valid (wb_valid),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .err      (err)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Present one op for exactly one accept edge; returns just after that edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk1);
    ex_valid  = 1'b1;
    ex_load   = ld;
    ex_store  = st;
    ex_funct3 = f3;
    ex_addr   = addr;
    ex_wdata  = wd;
    ex_rd     = rd;
    step();
    ex_valid = 1'b0;
    ex_load  = 1'b0;
    ex_store = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [4:0] rd, input logic [31:0] exp_data);
    issue(1'b1, 1'b0, f3, addr, 32'd0, rd);
    check({tag, "_req"}, {31'd0, dm_req}, 32'd1);
    check({tag, "_we"}, {31'd0, dm_we}, 32'd0);
    check({tag, "_be"}, {28'd0, dm_be}, 32'hF);
    step();
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp_data);
    check({tag, "_rd"}, {27'd0, wb_rd}, {27'd0, rd});
    check({tag, "_wbwe"}, {31'd0, wb_we}, {31'd0, (rd != 5'd0)});
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    step();
    check({tag, "_rdy"}, {31'd0, ex_ready}, 32'd1);
    check({tag, "_wbv0"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    int n;

    #3;
    check("rst_ready", {31'd0, ex_ready}, 32'd1);
    check("rst_req", {31'd0, dm_req}, 32'd0);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_be", {28'd0, dm_be}, 32'd0);
    check("rst_addr", {22'd0, dm_addr}, 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    @(negedge clk1);
    rst = 1'b1;
    dm_ack = 1'b1;

    // SW at 0x14
    issue(1'b0, 1'b1, 3'b010, 32'h14, 32'h0000_0405, 5'd1);
    check("sw_req", {31'd0, dm_req}, 32'd1);
    check("sw_addr", {22'd0, dm_addr}, 32'd5);
    check("sw_be", {28'd0, dm_be}, 32'hF);
    check("sw_wdata", dm_wdata, 32'h0000_0405);
    check("sw_we", {31'd0, dm_we}, 32'd1);
    check("sw_ready", {31'd0, ex_ready}, 32'd0);
    step();
    check("sw_req_off", {31'd0, dm_req}, 32'd0);
    check("sw_wbv", {31'd0, wb_valid}, 32'd0);
    check("sw_err", {31'd0, err}, 32'd0);
    step();
    check("sw_ready2", {31'd0, ex_ready}, 32'd1);

    // SB at 0x07
    issue(1'b0, 1'b1, 3'b000, 32'h07, 32'h0000_0405, 5'd1);
    check("sb_addr", {22'd0, dm_addr}, 32'd1);
    check("sb_be", {28'd0, dm_be}, 32'h8);
    check("sb_wdata", dm_wdata, 32'h0505_0505);
    step();
    step();

    // SH at 0x06
    issue(1'b0, 1'b1, 3'b001, 32'h06, 32'h0000_0405, 5'd1);
    check("sh_addr", {22'd0, dm_addr}, 32'd1);
    check("sh_be", {28'd0, dm_be}, 32'hC);
    check("sh_wdata", dm_wdata, 32'h0405_0405);
    step();
    check("sh_wbv", {31'd0, wb_valid}, 32'd0);
    step();

    load_case("lb", 3'b000, 32'h6, 5'd3, 32'hFFFF_FFF0);
    load_case("lbu", 3'b100, 32'h6, 5'd4, 32'h0000_00F0);
    load_case("lh", 3'b001, 32'h2, 5'd5, 32'h0000_12F0);
    load_case("lw", 3'b010, 32'h0, 5'd0, 32'h12F0_3456);
    check("hold_data", wb_data, 32'h12F0_3456);
    check("hold_rd", {27'd0, wb_rd}, 32'd0);

    // LW misaligned at 0x2
`ifdef MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h2, 32'd0, 5'd6);
    check("mis_req", {31'd0, dm_req}, 32'd0);
    check("mis_err", {31'd0, err}, 32'd1);
    check("mis_wbv", {31'd0, wb_valid}, 32'd0);
    step();
    check("mis_req2", {31'd0, dm_req}, 32'd0);
    check("mis_err2", {31'd0, err}, 32'd0);
    check("mis_ready", {31'd0, ex_ready}, 32'd1);
`else
    issue(1'b1, 1'b0, 3'b010, 32'h2, 32'd0, 5'd6);
    check("mis_addr", {22'd0, dm_addr}, 32'd0);
    step();
    check("mis_data", wb_data, 32'h12F0_3456);
    check("mis_err", {31'd0, err}, 32'd0);
    step();
`endif

    // Illegal load funct3 and load+store together
    issue(1'b1, 1'b0, 3'b011, 32'h0, 32'd0, 5'd7);
    check("ill_f3_err", {31'd0, err}, 32'd1);
    check("ill_f3_req", {31'd0, dm_req}, 32'd0);
    step();
    check("ill_f3_err2", {31'd0, err}, 32'd0);
    issue(1'b1, 1'b1, 3'b010, 32'h0, 32'd0, 5'd7);
    check("ill_ls_err", {31'd0, err}, 32'd1);
    check("ill_ls_wbv", {31'd0, wb_valid}, 32'd0);
    step();

    // No-op: stays idle
    issue(1'b0, 1'b0, 3'b010, 32'h0, 32'd0, 5'd7);
    check("nop_ready", {31'd0, ex_ready}, 32'd1);
    check("nop_req", {31'd0, dm_req}, 32'd0);
    check("nop_err", {31'd0, err}, 32'd0);

    // Timeout with ack held low
    dm_ack = 1'b0;
    issue(1'b1, 1'b0, 3'b010, 32'h8, 32'd0, 5'd8);
    n = 0;
    while (dm_req && n < 40) begin
      n++;
      step();
    end
    check("to_cycles", n, 32'd15);
    check("to_err", {31'd0, err}, 32'd1);
    check("to_wbv", {31'd0, wb_valid}, 32'd0);
    check("to_ready0", {31'd0, ex_ready}, 32'd0);
    step();
    check("to_ready", {31'd0, ex_ready}, 32'd1);
    check("to_err2", {31'd0, err}, 32'd0);

    // Reset while waiting for ack
    issue(1'b1, 1'b0, 3'b010, 32'h8, 32'd0, 5'd9);
    step();
    check("ra_req_pre", {31'd0, dm_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("ra_req", {31'd0, dm_req}, 32'd0);
    check("ra_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk1);
    rst = 1'b1;
    dm_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ra_wbv", {31'd0, wb_valid}, 32'd0);
      check("ra_err", {31'd0, err}, 32'd0);
      check("ra_req_post", {31'd0, dm_req}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, 10, data-memory word-address width.
REQ-002 SHALL have parameter TIMEOUT, 15, maximum cycles to wait for dm_ack (range 1..255).
REQ-003 SHALL have port clk1  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ex_valid  input  1  execute stage presents a memory op.
REQ-006 SHALL have port ex_ready  output  1  unit can accept an op this cycle.
REQ-007 SHALL have ports ex_load, ex_store  input  1 each  op kind.
REQ-008 SHALL have ports ex_funct3  input  3, ex_addr  input  32, ex_wdata  input  32, ex_rd  input  5.
REQ-009 SHALL have ports dm_req, dm_we  output  1; dm_be  output  4; dm_addr  output  ADDR_W; dm_wdata  output  32.
REQ-010 SHALL have ports dm_ack  input  1, dm_rdata  input  32.
REQ-011 SHALL have ports wb_valid, wb_we  output  1; wb_rd  output  5; wb_data  output  32; err  output  1.

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, FINISH; ex_ready = 1 only in IDLE.
REQ-013 SHALL accept an op on a rising edge with ex_valid=1 and ex_ready=1; the op's fields are registered at accept.
REQ-014 SHALL treat an accepted op with neither load nor store as a no-op: stay IDLE, no dm_req, no wb_valid, no err.
REQ-015 SHALL treat as illegal: load and store both high, load funct3 not in {000,001,010,100,101}, store funct3 not in {000,001,010}; illegal -> FINISH with a one-cycle err pulse, no dm_req.
REQ-016 SHALL in ACCESS hold dm_req=1 with dm_addr = addr[ADDR_W+1:2] and dm_we/dm_be/dm_wdata stable until dm_ack is sampled high.
REQ-017 Store byte enables SHALL be: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; dm_wdata = byte (SB) or half (SH) replicated across all lanes; loads drive dm_we=0, dm_be=1111.
REQ-018 On dm_ack in ACCESS, SHALL drop dm_req and go to FINISH; FINISH lasts exactly one cycle, then IDLE.
REQ-019 For loads, SHALL in FINISH assert wb_valid for one cycle with wb_rd=rd, wb_we = (rd != 0), wb_data = selected lane of dm_rdata captured at ack, sign-extended (LB, LH) or zero-extended (LBU, LHU); LW passes the word unchanged.
REQ-020 For stores, wb_valid SHALL stay 0.
REQ-021 Latency with dm_ack tied high: accept edge N, dm_req high N..N+1, wb_valid high N+1..N+2, next accept at edge N+2.
REQ-022 SHALL count cycles in ACCESS; if TIMEOUT cycles elapse without dm_ack, drop dm_req, go to FINISH with a one-cycle err pulse and no wb_valid.
REQ-023 dm_ack outside ACCESS SHALL be ignored.
REQ-024 wb_data, wb_rd SHALL hold their last values when wb_valid=0.

Reset
REQ-025 While rst=0: state IDLE, ex_ready=1; dm_req, dm_we, wb_valid, wb_we, err = 0; dm_be, dm_addr, dm_wdata, wb_rd, wb_data, timeout counter = 0.
REQ-026 Reset asserted mid-access SHALL drop dm_req immediately (asynchronously); the aborted op SHALL produce no wb_valid or err after release.

Configuration
REQ-027 Macro MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL be treated as illegal per REQ-015 (err pulse, no dm_req).
REQ-028 MISALIGN_TRAP_EN undefined: such accesses SHALL proceed with offending low address bits forced to 0; err never asserts for misalignment.

Verification
REQ-029 SW, ex_wdata=0x00000405, addr=0x14, dm_ack=1 -> one dm_req cycle, dm_addr=5, dm_be=1111, dm_wdata=0x00000405, dm_we=1, no wb_valid.
REQ-030 SB, ex_wdata=0x00000405, addr=0x07 -> dm_addr=1, dm_be=1000, dm_wdata=0x05050505; SH at addr=0x06 -> dm_be=1100, dm_wdata=0x04050405.
REQ-031 dm_rdata=0x12F03456: LB addr 0x6 -> wb_data=0xFFFFFFF0; LBU addr 0x6 -> 0x000000F0; LH addr 0x2 -> 0x000012F0; LW addr 0x0, rd=0 -> wb_valid=1, wb_we=0.
REQ-032 LW addr=0x2: with MISALIGN_TRAP_EN -> err pulse, dm_req never high; without -> dm_addr=0, wb_data=dm_rdata, err=0.
REQ-033 dm_ack held 0, TIMEOUT=15 -> dm_req high exactly 15 cycles, then err pulse, ex_ready=1 one cycle later, no wb_valid.
REQ-034 rst driven low while dm_req waits for ack -> dm_req=0 same cycle, ex_ready=1; after release no wb_valid or err.
